// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central hazard / exception controller for the five-stage core.
//
// It merges the stage stall requests into hold and bubble controls for each
// pipeline boundary. It sequences exception flushes, and defers a flush while
// an instruction-fetch bus transaction is outstanding. It also counts the
// cycles in which the PC is held.
//
// Parameters
//   ADDR_WIDTH    width of exception / redirect PC
//   CNT_WIDTH     width of stall-cycle counter
//
// Ports
//   clk           core clock, rising edge
//   rst           synchronous reset, active low
//   stall_req_if  fetch waiting on instruction bus
//   stall_req_id  load-use / operand hazard
//   stall_req_ex  multi-cycle mul/div busy
//   stall_req_mem data bus waiting
//   if_busy       instruction-bus transaction outstanding
//   exc_req       exception/eret committed by the instruction in MEM
//   exc_pc        redirect target for exc_req
//   stall[4:0]    hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM,
//                 [4] MEM/WB
//   bubble[4:0]   same bit order; register loads a NOP instead of its input
//   flush         clear all pipeline registers, load PC with flush_pc
//   flush_pc      redirect PC (meaningful while flush=1)
//   stall_cycles  number of cycles with stall[0]=1 (wraps)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  if_busy,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  output logic [4:0]            stall,
  output logic [4:0]            bubble,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FLUSH_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_pend_pc;
  logic [ADDR_WIDTH-1:0] w_pend_pc_next;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;
  logic                  w_exc_q;

  // An exception held by MEM during a data-bus stall must wait until the
  // stall clears; the stall itself still takes effect meanwhile.
  assign w_exc_q = exc_req & ~stall_req_mem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_pend_pc      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pend_pc <= w_pend_pc_next;
      if (stall[0]) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pend_pc_next = r_pend_pc;
    stall          = 5'b00000;
    bubble         = 5'b00000;
    flush          = 1'b0;
    flush_pc       = (r_state == ST_FLUSH_WAIT) ? r_pend_pc : exc_pc;

    case (r_state)
      ST_RUN: begin
        if (w_exc_q) begin
          if (if_busy) begin
            // Fetch transaction cannot be abandoned: freeze everything and
            // remember the target until the bus goes idle.
            w_pend_pc_next = exc_pc;
            w_state_next   = ST_FLUSH_WAIT;
            stall          = 5'b11111;
          end else begin
            flush = 1'b1;
          end
        end else if (stall_req_mem) begin
          stall  = 5'b01111;
          bubble = 5'b10000;
        end else if (stall_req_ex) begin
          stall  = 5'b00111;
          bubble = 5'b01000;
        end else if (stall_req_id) begin
          stall  = 5'b00011;
          bubble = 5'b00100;
        end else if (stall_req_if) begin
          stall  = 5'b00001;
          bubble = 5'b00010;
        end
      end
      ST_FLUSH_WAIT: begin
        // Stall requests and further exceptions are ignored while pending.
        if (if_busy) begin
          stall = 5'b11111;
        end else begin
          flush        = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // Outputs are forced quiet for the whole time reset is asserted.
    if (!rst) begin
      stall    = 5'b00000;
      bubble   = 5'b00000;
      flush    = 1'b0;
      flush_pc = '0;
    end
  end

  assign stall_cycles = rst ? r_stall_cycles : '0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;   // narrow counter so wrap-around is reachable

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic          if_busy, exc_req;
  logic [AW-1:0] exc_pc;
  logic [4:0]    stall, bubble;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [CW-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit            m_pending;
  logic [AW-1:0] m_pend_pc;
  logic [CW-1:0] m_cnt;

  // Expected values for the current cycle
  logic [4:0]    e_stall, e_bubble;
  logic          e_flush;
  logic [AW-1:0] e_pc;
  logic [CW-1:0] e_cnt;

  pipeline_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_if (stall_req_if),
    .stall_req_id (stall_req_id),
    .stall_req_ex (stall_req_ex),
    .stall_req_mem(stall_req_mem),
    .if_busy      (if_busy),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs from the current inputs and model state, then compare.
  task automatic eval_check();
    int d;
    e_stall = '0; e_bubble = '0; e_flush = 1'b0; e_pc = '0; e_cnt = '0;
    if (rst) begin
      e_cnt = m_cnt;
      if (m_pending) begin
        e_pc = m_pend_pc;
        if (if_busy) e_stall = 5'h1f; else e_flush = 1'b1;
      end else begin
        e_pc = exc_pc;
        if (exc_req && !stall_req_mem) begin
          if (if_busy) e_stall = 5'h1f; else e_flush = 1'b1;
        end else begin
          // deepest requesting stage index: if=1 .. mem=4
          d = stall_req_mem ? 4 : stall_req_ex ? 3 : stall_req_id ? 2 : stall_req_if ? 1 : 0;
          if (d > 0) begin
            e_stall  = 5'((1 << d) - 1);
            e_bubble = 5'(1 << d);
          end
        end
      end
    end
    chk("stall",        64'(stall),        64'(e_stall));
    chk("bubble",       64'(bubble),       64'(e_bubble));
    chk("flush",        64'(flush),        64'(e_flush));
    chk("flush_pc",     64'(flush_pc),     64'(e_pc));
    chk("stall_cycles", 64'(stall_cycles), 64'(e_cnt));
    $display("t=%0t rst=%b req(m,e,i,f)=%b%b%b%b busy=%b exc=%b pc=%h | stall=%b bubble=%b flush=%b fpc=%h cnt=%0d",
             $time, rst, stall_req_mem, stall_req_ex, stall_req_id, stall_req_if,
             if_busy, exc_req, exc_pc, stall, bubble, flush, flush_pc, stall_cycles);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_pending = 1'b0;
      m_pend_pc = '0;
      m_cnt     = '0;
    end else begin
      m_cnt = m_cnt + CW'(e_stall[0]);
      if (m_pending) begin
        if (!if_busy) m_pending = 1'b0;
      end else if (exc_req && !stall_req_mem && if_busy) begin
        m_pending = 1'b1;
        m_pend_pc = exc_pc;
      end
    end
    #1;
  endtask

  task automatic cyc();
    #2;
    eval_check();
    tick();
  endtask

  task automatic set_req(input logic m, input logic e, input logic i, input logic f);
    stall_req_mem = m; stall_req_ex = e; stall_req_id = i; stall_req_if = f;
  endtask

  initial begin
    m_pending = 1'b0; m_pend_pc = '0; m_cnt = '0;
    // Reset with every request high for 3 cycles
    rst = 1'b0; set_req(1, 1, 1, 1); if_busy = 1'b1; exc_req = 1'b1; exc_pc = 32'h1234_5678;
    #1;
    for (int i = 0; i < 3; i++) begin
      #2; eval_check();
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      tick();
    end

    // Release: plain RUN
    rst = 1'b1; set_req(0, 0, 0, 0); if_busy = 1'b0; exc_req = 1'b0; exc_pc = '0;
    cyc();

    // Priority: id + mem, then id alone
    set_req(1, 0, 1, 0);
    #2; eval_check(); chk("prio_mem", 64'(stall), 64'h0f); tick();
    set_req(0, 0, 1, 0);
    #2; eval_check(); chk("prio_id", 64'(bubble), 64'h04); tick();
    set_req(0, 0, 0, 0);

    // Immediate flush
    exc_req = 1'b1; exc_pc = 32'hBFC0_0380;
    #2; eval_check(); chk("imm_flush", 64'(flush), 64'd1); tick();
    exc_req = 1'b0;
    cyc();

    // Deferred flush: exc_pc changes after the first cycle; first PC wins
    exc_req = 1'b1; exc_pc = 32'h8000_0180; if_busy = 1'b1;
    cyc();
    exc_pc = '0;
    cyc();
    cyc();
    if_busy = 1'b0; exc_req = 1'b0;
    #2; eval_check(); chk("def_flush_pc", 64'(flush_pc), 64'h8000_0180); tick();
    cyc();

    // Exception under mem stall
    exc_req = 1'b1; exc_pc = 32'h0000_0400; set_req(1, 0, 0, 0);
    cyc(); cyc();
    set_req(0, 0, 0, 0);
    #2; eval_check(); chk("mem_exc_flush", 64'(flush), 64'd1); tick();
    exc_req = 1'b0;

    // Counter: reset, 4 cycles of IF stall, then wrap after 16
    rst = 1'b0; cyc(); rst = 1'b1;
    set_req(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc();
    #2; eval_check(); chk("cnt_4", 64'(stall_cycles), 64'd4); tick();
    for (int i = 0; i < 11; i++) cyc();
    #2; eval_check(); chk("cnt_wrap", 64'(stall_cycles), 64'd0); tick();
    set_req(0, 0, 0, 0);

    // Reset mid FLUSH_WAIT drops the pending flush
    exc_req = 1'b1; exc_pc = 32'hDEAD_BEE0; if_busy = 1'b1;
    cyc();
    exc_req = 1'b0;
    cyc();
    rst = 1'b0; if_busy = 1'b0;
    cyc();
    rst = 1'b1;
    #2; eval_check();
    chk("post_rst_flush", 64'(flush), 64'd0);
    chk("post_rst_cnt", 64'(stall_cycles), 64'd0);
    tick();

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(99) >= 3);
      stall_req_if  = ($urandom_range(99) < 30);
      stall_req_id  = ($urandom_range(99) < 25);
      stall_req_ex  = ($urandom_range(99) < 20);
      stall_req_mem = ($urandom_range(99) < 20);
      if_busy       = ($urandom_range(99) < 50);
      exc_req       = ($urandom_range(99) < 20);
      exc_pc        = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
